// File: rtl/csi_rx_byte_align.sv
// csi_rx_byte_align: per-lane HS sync hunter and byte aligner in the byte_clock domain.
// Define CSI_RX_SYNC_ERR_TOL_EN to also accept a sync byte with a single bit error.
module csi_rx_byte_align #(
    parameter logic [7:0]  SYNC_PATTERN = 8'hB8,
    parameter int unsigned HUNT_TIMEOUT = 0
) (
    input  logic       byte_clock,
    input  logic       reset,
    input  logic       enable,
    input  logic       wait_for_sync,
    input  logic       packet_done,
    input  logic [7:0] deser_in,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic [2:0] sync_offset,
    output logic       locked,
    output logic       sync_soft_err,
    output logic       hunt_timeout
);

    typedef enum logic [1:0] {IDLE, HUNT, LOCKED} state_t;

    localparam logic [15:0] TIMEOUT_LAST = 16'(HUNT_TIMEOUT - 1);

    state_t      state;
    logic [7:0]  curr_q;
    logic [7:0]  prev_q;
    logic [15:0] win;
    logic [15:0] hunt_cnt;
    logic [7:0]  exact;
    logic        hit;
    logic        hit_soft;
    logic [2:0]  hit_k;

    function automatic logic [2:0] lowest(input logic [7:0] v);
        lowest = 3'd0;
        for (int k = 7; k >= 0; k--)
            if (v[k]) lowest = 3'(k);
    endfunction

    // prev_q holds the earlier word, so bit 0 of the window is earliest in time
    assign win = {curr_q, prev_q};

    always_comb begin
        exact = '0;
        for (int k = 0; k < 8; k++)
            exact[k] = (win[k +: 8] == SYNC_PATTERN);
    end

`ifdef CSI_RX_SYNC_ERR_TOL_EN
    logic [7:0] near;

    function automatic logic one_bit(input logic [7:0] v);
        one_bit = (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
    endfunction

    always_comb begin
        near = '0;
        for (int k = 0; k < 8; k++)
            near[k] = one_bit(win[k +: 8] ^ SYNC_PATTERN);
    end

    // an exact match anywhere beats a 1-bit match at a lower offset
    assign hit      = (|exact) | (|near);
    assign hit_soft = ~(|exact) & (|near);
    assign hit_k    = (|exact) ? lowest(exact) : lowest(near);
`else
    assign hit      = |exact;
    assign hit_soft = 1'b0;
    assign hit_k    = lowest(exact);
`endif

    always_ff @(posedge byte_clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            curr_q        <= '0;
            prev_q        <= '0;
            hunt_cnt      <= '0;
            data_out      <= '0;
            data_valid    <= 1'b0;
            sync_offset   <= '0;
            locked        <= 1'b0;
            sync_soft_err <= 1'b0;
            hunt_timeout  <= 1'b0;
        end else begin
            curr_q        <= deser_in;
            prev_q        <= curr_q;
            hunt_cnt      <= '0;
            data_valid    <= 1'b0;
            sync_soft_err <= 1'b0;
            hunt_timeout  <= 1'b0;
            if (!enable) begin
                state  <= IDLE;
                locked <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (wait_for_sync) state <= HUNT;
                    end
                    HUNT: begin
                        if (hit) begin
                            state         <= LOCKED;
                            locked        <= 1'b1;
                            sync_offset   <= hit_k;
                            sync_soft_err <= hit_soft;
                        end else begin
                            if (!wait_for_sync) state <= IDLE;
                            if (HUNT_TIMEOUT != 0) begin
                                if (hunt_cnt == TIMEOUT_LAST) begin
                                    hunt_timeout <= 1'b1;
                                end else begin
                                    hunt_cnt <= hunt_cnt + 16'd1;
                                end
                            end
                        end
                    end
                    LOCKED: begin
                        if (packet_done) begin
                            state  <= wait_for_sync ? HUNT : IDLE;
                            locked <= 1'b0;
                        end else begin
                            data_out   <= win[sync_offset +: 8];
                            data_valid <= 1'b1;
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_csi_rx_byte_align.sv
// tb_csi_rx_byte_align: directed vectors for the byte aligner.
// Optional-build expectations follow CSI_RX_SYNC_ERR_TOL_EN.
module tb_csi_rx_byte_align;

`ifdef CSI_RX_SYNC_ERR_TOL_EN
    localparam logic TOL = 1'b1;
`else
    localparam logic TOL = 1'b0;
`endif

    logic       byte_clock = 1'b0;
    logic       reset;
    logic       enable;
    logic       wait_for_sync;
    logic       packet_done;
    logic [7:0] deser_in;
    logic [7:0] data_out;
    logic       data_valid;
    logic [2:0] sync_offset;
    logic       locked;
    logic       sync_soft_err;
    logic       hunt_timeout;

    int checks = 0;
    int errors = 0;

    csi_rx_byte_align #(
        .SYNC_PATTERN(8'hB8),
        .HUNT_TIMEOUT(16)
    ) dut (
        .byte_clock(byte_clock),
        .reset(reset),
        .enable(enable),
        .wait_for_sync(wait_for_sync),
        .packet_done(packet_done),
        .deser_in(deser_in),
        .data_out(data_out),
        .data_valid(data_valid),
        .sync_offset(sync_offset),
        .locked(locked),
        .sync_soft_err(sync_soft_err),
        .hunt_timeout(hunt_timeout)
    );

    always #5 byte_clock = ~byte_clock;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge byte_clock);
        #1;
    endtask

    task automatic send(input logic [7:0] w);
        deser_in = w;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        enable = 1'b0;
        wait_for_sync = 1'b0;
        packet_done = 1'b0;
        deser_in = 8'h00;
        tick();
        tick();
        check("rst_data", data_out, 8'h00);
        check("rst_valid", 8'(data_valid), 8'h00);
        check("rst_locked", 8'(locked), 8'h00);
        check("rst_offset", 8'(sync_offset), 8'h00);
        check("rst_timeout", 8'(hunt_timeout), 8'h00);
        check("rst_soft", 8'(sync_soft_err), 8'h00);
        reset = 1'b0;
        enable = 1'b1;
        wait_for_sync = 1'b1;
        send(8'h00);

        // sync at offset 0, payload AA 55
        send(8'h00);
        send(8'hB8);
        send(8'hAA);
        check("t1_prelock", 8'(locked), 8'h00);
        send(8'h55);
        check("t1_locked", 8'(locked), 8'h01);
        check("t1_offset", 8'(sync_offset), 8'h00);
        check("t1_sync_hidden", 8'(data_valid), 8'h00);
        send(8'h00);
        check("t1_valid", 8'(data_valid), 8'h01);
        check("t1_byte0", data_out, 8'hAA);
        send(8'h00);
        check("t1_byte1", data_out, 8'h55);

        // packet_done with a sync in the window, then relock at offset 5
        send(8'hB8);
        send(8'h00);
        packet_done = 1'b1;
        send(8'h00);
        check("t3_pd_valid", 8'(data_valid), 8'h00);
        check("t3_pd_locked", 8'(locked), 8'h00);
        packet_done = 1'b0;
        send(8'h00);
        check("t3_nocapture", 8'(locked), 8'h00);
        send(8'h57);
        check("t3_prelock", 8'(locked), 8'h00);
        send(8'h0B);
        check("t3_locked", 8'(locked), 8'h01);
        check("t3_offset", 8'(sync_offset), 8'h05);
        send(8'h00);
        check("t3_valid", 8'(data_valid), 8'h01);
        check("t3_byte0", data_out, 8'h5A);

        // asynchronous reset mid-payload
        reset = 1'b1;
        #1;
        check("t4_rst_valid", 8'(data_valid), 8'h00);
        check("t4_rst_locked", 8'(locked), 8'h00);
        check("t4_rst_data", data_out, 8'h00);
        check("t4_rst_offset", 8'(sync_offset), 8'h00);
        #1;
        reset = 1'b0;
        send(8'h00);
        send(8'hB8);
        send(8'hAA);
        send(8'h55);
        send(8'h00);
        check("t4_relock_valid", 8'(data_valid), 8'h01);
        enable = 1'b0;
        send(8'h00);
        check("t4_en_valid", 8'(data_valid), 8'h00);
        check("t4_en_locked", 8'(locked), 8'h00);
        enable = 1'b1;
        wait_for_sync = 1'b0;
        send(8'hB8);
        send(8'hAA);
        send(8'h00);
        check("t4_idle_nolock", 8'(locked), 8'h00);

        // sync shifted by 3 bits: B8 3C C3
        wait_for_sync = 1'b1;
        send(8'h00);
        send(8'hC0);
        check("t2_early0", 8'(locked), 8'h00);
        send(8'hE5);
        check("t2_early1", 8'(locked), 8'h00);
        send(8'h19);
        check("t2_locked", 8'(locked), 8'h01);
        check("t2_offset", 8'(sync_offset), 8'h03);
        send(8'h06);
        check("t2_byte0", data_out, 8'h3C);
        send(8'h00);
        check("t2_byte1", data_out, 8'hC3);

        // 2-bit error never locks, 1-bit error locks only in the tolerant build
        enable = 1'b0;
        send(8'h00);
        enable = 1'b1;
        send(8'h00);
        send(8'h78);
        send(8'h00);
        send(8'h00);
        send(8'h00);
        check("t5_2bit_nolock", 8'(locked), 8'h00);
        send(8'hB9);
        send(8'h00);
        send(8'h00);
        check("t5_1bit_locked", 8'(locked), 8'(TOL));
        check("t5_1bit_soft", 8'(sync_soft_err), 8'(TOL));
        send(8'h00);
        check("t5_soft_pulse", 8'(sync_soft_err), 8'h00);

        // timeout every 16 HUNT cycles
        enable = 1'b0;
        send(8'h00);
        enable = 1'b1;
        send(8'h00);
        for (int i = 1; i <= 32; i++) begin
            send(8'h00);
            check($sformatf("t6_to_%0d", i), 8'(hunt_timeout),
                  8'((i == 16) || (i == 32)));
        end
        check("t6_still_hunt", 8'(locked), 8'h00);

        // a lock restarts the count from zero
        enable = 1'b0;
        send(8'h00);
        enable = 1'b1;
        send(8'h00);
        for (int i = 1; i <= 20; i++) begin
            if (i == 18) send(8'hB8);
            else if (i == 19) send(8'hAA);
            else send(8'h00);
        end
        check("t6_lock20", 8'(locked), 8'h01);
        packet_done = 1'b1;
        send(8'h00);
        packet_done = 1'b0;
        for (int j = 1; j <= 16; j++) begin
            send(8'h00);
            check($sformatf("t6_rehunt_%0d", j), 8'(hunt_timeout), 8'(j == 16));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
